// File: rtl/mic_pkg.sv
// Shared constants, types and the saturating gain helper for the microphone
// decimation path.
package mic_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int LOG2_DECIM_DEF = 2;
  localparam int DECIM_N        = 1 << LOG2_DECIM_DEF;
  localparam int SAT_W          = 32;

  typedef logic [1:0] gain_t;

  // Computed in SAT_W+3 bits so the largest shift (3) can never wrap before clamping.
  function automatic logic [SAT_W-1:0] sat_shl(input logic [SAT_W-1:0] avg,
                                               input gain_t shift,
                                               input int unsigned width);
    logic [SAT_W+2:0] scaled;
    logic [SAT_W+2:0] limit;
    scaled = {3'b000, avg} << shift;
    limit  = ((SAT_W+3)'(1) << width) - (SAT_W+3)'(1);
    return (scaled > limit) ? limit[SAT_W-1:0] : scaled[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/mic_decimator_if.sv
// Control, sample and observability signals between the ADC-side driver and
// the decimator.
interface mic_decimator_if
  import mic_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int LOG2_DECIM = LOG2_DECIM_DEF
);
  logic                  en;
  logic                  flush;
  logic                  adc_valid;
  logic [WIDTH-1:0]      adc_data;
  gain_t                 gain_shift;
  logic [WIDTH-1:0]      mic_signal;
  logic                  sample_valid;
  logic [LOG2_DECIM-1:0] phase;

  modport master (
    output en, flush, adc_valid, adc_data, gain_shift,
    input  mic_signal, sample_valid, phase
  );

  modport slave (
    input  en, flush, adc_valid, adc_data, gain_shift,
    output mic_signal, sample_valid, phase
  );
endinterface

// File: rtl/mic_decimator.sv
// Boxcar decimator: averages non-overlapping blocks of 2^LOG2_DECIM accepted
// ADC samples and emits one saturated, gain-shifted sample per block.
module mic_decimator
  import mic_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int LOG2_DECIM = LOG2_DECIM_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mic_decimator_if.slave  bus
);
  // state   | meaning
  // ACCUM(p)| p samples of the current block accumulated (phase_q == p)

  localparam int AW    = WIDTH + LOG2_DECIM;
  localparam int DECIM = 1 << LOG2_DECIM;

  logic [AW-1:0]         acc_q, acc_d;
  logic [LOG2_DECIM-1:0] phase_q, phase_d;
  logic [WIDTH-1:0]      mic_q, mic_d;
  logic                  sv_q, sv_d;

  logic                  accept;
  logic                  last;
  logic [AW-1:0]         sum;
  logic [WIDTH-1:0]      avg;
  logic [WIDTH-1:0]      scaled_sat;

  assign accept     = bus.en && bus.adc_valid && !bus.flush;
  assign last       = (phase_q == LOG2_DECIM'(DECIM - 1));
  // AW bits hold N full-scale samples, so the sum cannot overflow.
  assign sum        = acc_q + AW'(bus.adc_data);
  assign avg        = WIDTH'(sum >> LOG2_DECIM);
  assign scaled_sat = WIDTH'(sat_shl(SAT_W'(avg), bus.gain_shift, unsigned'(WIDTH)));

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    mic_d   = mic_q;
    sv_d    = 1'b0;
    if (bus.flush) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (accept) begin
      if (last) begin
        acc_d   = '0;
        phase_d = '0;
        mic_d   = scaled_sat;
        sv_d    = 1'b1;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + LOG2_DECIM'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      phase_q <= '0;
      mic_q   <= '0;
      sv_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      mic_q   <= mic_d;
      sv_q    <= sv_d;
    end
  end

  assign bus.mic_signal   = mic_q;
  assign bus.sample_valid = sv_q;
  assign bus.phase        = phase_q;

endmodule

// File: doc/mic_decimator.md
Name: mic_decimator

Overview:
- Upstream feeder for the signal-delay stage: accepts raw microphone/ADC samples at the ADC rate and emits one averaged, gain-scaled sample per 2^LOG2_DECIM accepted inputs.
- Output sample drives the delay stage's data input (mic_signal); the one-cycle sample_valid pulse drives the delay stage's counter enable and RAM write strobe.
- Averaging is a boxcar over non-overlapping blocks. Gain is a left shift with saturation.

Parameters:
- WIDTH, 8, bit width of ADC samples and of the output sample (unsigned, offset binary).
- LOG2_DECIM, 2, log2 of the decimation factor N (N = 4 by default). Legal range is 1..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  block enable; when low, adc_valid is ignored and all state holds
- flush  input  1  synchronous clear of the partial accumulation
- adc_valid  input  1  adc_data is valid this cycle
- adc_data  input  WIDTH  raw unsigned microphone sample
- gain_shift  input  2  output left-shift amount, 0..3
- mic_signal  output  WIDTH  registered decimated sample
- sample_valid  output  1  one-cycle pulse marking a new mic_signal
- phase  output  LOG2_DECIM  samples accepted in the current block (debug/observability)

Behaviour:
- Reset (async, any time): acc=0, phase=0, mic_signal=0, sample_valid=0. Takes effect immediately; no output pulse while rst is high.
- Accept condition: accept = en && adc_valid && !flush.
- Accumulator:
  - Width is WIDTH+LOG2_DECIM and can never overflow (max N*(2^WIDTH-1)).
  - Phase counter 0..N-1 is the only FSM state: ACCUM(phase).
- On accept with phase < N-1:
  - acc <= acc + adc_data; phase <= phase+1; sample_valid <= 0.
- On accept with phase == N-1 (block complete):
  - sum = acc + adc_data; avg = sum >> LOG2_DECIM (truncate).
  - scaled = avg << gain_shift, computed in WIDTH+3 bits.
  - mic_signal <= (scaled > 2^WIDTH-1) ? 2^WIDTH-1 : scaled.
  - sample_valid <= 1; acc <= 0; phase <= 0.
- Latency: mic_signal and sample_valid update on the same rising edge that accepts the N-th sample, so both are visible in the following cycle. sample_valid is high for exactly one cycle.
- No accept: sample_valid <= 0. acc, phase and mic_signal hold.
- mic_signal holds its last value between pulses. Downstream may sample it at any time.
- gain_shift is sampled only on the completing edge. Changes mid-block affect only that block's output.
- flush:
  - acc <= 0, phase <= 0, sample_valid <= 0.
  - Takes priority over a simultaneous adc_valid; that sample is discarded.
  - flush works regardless of en.
  - mic_signal is unchanged.
- en low:
  - Partial block is retained; accumulation resumes when en returns.
  - Gaps in adc_valid likewise do not break a block.
- Back-to-back: adc_valid high every cycle yields one sample_valid every N cycles, with no dead cycle between blocks.

Decomposition:
- Package mic_pkg:
  - Constant DECIM_N = 1 << LOG2_DECIM default.
  - Typedef for the gain_shift field.
  - Function sat_shl(avg, shift) returning the saturated WIDTH-bit result, shared with future gain stages.
- No sub-module: a single always_ff for acc/phase/outputs plus the combinational sum/avg/saturate path.

Test Plan (WIDTH=8, LOG2_DECIM=2):
- Reset, then adc_data 10,20,30,40 on 4 consecutive valid cycles with gain_shift=0 → mic_signal=25, sample_valid high for exactly 1 cycle, in the cycle after the 4th sample; phase=0.
- Inputs 100,100,100,100 with gain_shift=1 → 200. Repeat with gain_shift=2 → 255 (saturated). Inputs 255 ×4 with gain_shift=0 → 255 (no accumulator overflow).
- Inputs 10,20 then flush asserted together with adc_valid (data 99), then 4,4,4,4 → output 4; the 99 is discarded.
- Inputs 1,2 with en high; en low for 5 cycles with adc_valid=1 and data=200; en high; inputs 3,6 → output 3; sample_valid stays 0 throughout the gap.
- adc_valid continuously high for 16 cycles with data ramp 0..15 → 4 pulses spaced exactly 4 cycles apart, values 1,5,9,13.
- Inputs 50,50,50 then async rst pulse mid-cycle → mic_signal=0 and phase=0 immediately. Then 8,8,8,8 → output 8.
